// File: rtl/psk_burst_phase_accum.sv
// psk_burst_phase_accum: M-PSK burst phase accumulator; CLK/RESET, burst config (PHASE_INC,T_IMPULSE,T_PERIOD,NUM_OF_IMP,CHIP_LEN,CODE_NUM,CODE), SIGN_START_GEN/OUT_REG_READY in; ROM_ADDRESS, SIGN_START_CALC/SIGN_STOP_CALC strobes, BUSY out
module psk_burst_phase_accum #(
  parameter int ACC_W = 32,
  parameter int ADDR_W = 12,
  parameter int PHASE_BITS = 1,
  parameter int MAX_CHIPS = 16,
  parameter int CNT_W = 16,
  parameter int PHASE_CONT = 0
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic [ACC_W-1:0]                PHASE_INC,
  input  logic [CNT_W-1:0]                T_IMPULSE,
  input  logic [CNT_W-1:0]                T_PERIOD,
  input  logic [7:0]                      NUM_OF_IMP,
  input  logic [CNT_W-1:0]                CHIP_LEN,
  input  logic [$clog2(MAX_CHIPS):0]      CODE_NUM,
  input  logic [MAX_CHIPS*PHASE_BITS-1:0] CODE,
  input  logic                            SIGN_START_GEN,
  input  logic                            OUT_REG_READY,
  output logic [ADDR_W-1:0]               ROM_ADDRESS,
  output logic                            SIGN_START_CALC,
  output logic                            SIGN_STOP_CALC,
  output logic                            BUSY
);
  localparam int CW = $clog2(MAX_CHIPS) + 1;
  localparam int IW = $clog2(MAX_CHIPS);
  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;
  state_t state, state_n;
  logic start_q, armed, start_edge, cfg_ok, load, start_n, stop_n, chip_end;
  logic [ACC_W-1:0] inc_s, acc, acc_n;
  logic [CNT_W-1:0] t_imp_s, t_per_s, chip_len_s, gap_last;
  logic [CNT_W-1:0] cyc, cyc_n, chip_cnt, chip_cnt_n;
  logic [7:0] num_s, pulse_cnt, pulse_cnt_n;
  logic [CW-1:0] code_num_s;
  logic [MAX_CHIPS*PHASE_BITS-1:0] code_s;
  logic [IW-1:0] chip_idx, chip_idx_n;
  logic [PHASE_BITS-1:0] syms [MAX_CHIPS];
  logic [ADDR_W-1:0] addr_n;
  function automatic logic [ADDR_W-1:0] rom_addr(input logic [ACC_W-1:0] a, input logic [PHASE_BITS-1:0] s);
    return a[ACC_W-1 -: ADDR_W] + {s, {(ADDR_W-PHASE_BITS){1'b0}}};
  endfunction
  for (genvar j = 0; j < MAX_CHIPS; j++) begin : g_sym
    assign syms[j] = code_s[j*PHASE_BITS +: PHASE_BITS];
  end
  // armed blocks the first post-reset cycle so an input already high at release is not taken as an edge
  assign start_edge = armed & SIGN_START_GEN & ~start_q;
  assign cfg_ok = |NUM_OF_IMP && |T_IMPULSE && |CHIP_LEN && |CODE_NUM;
  assign gap_last = t_per_s > t_imp_s ? t_per_s - t_imp_s - 1'b1 : '0;
  assign chip_end = chip_cnt == chip_len_s - 1'b1;
  always_comb begin
    state_n = state;
    acc_n = acc;
    cyc_n = cyc;
    chip_cnt_n = chip_cnt;
    chip_idx_n = chip_idx;
    pulse_cnt_n = pulse_cnt;
    addr_n = ROM_ADDRESS;
    start_n = 1'b0;
    stop_n = 1'b0;
    load = 1'b0;
    if (OUT_REG_READY)
      case (state)
        IDLE: if (start_edge) begin
          load = 1'b1;
          if (cfg_ok) begin
            state_n = PULSE;
            acc_n = PHASE_CONT != 0 ? acc : '0;
            cyc_n = '0;
            chip_cnt_n = '0;
            chip_idx_n = '0;
            pulse_cnt_n = '0;
            addr_n = rom_addr(acc_n, CODE[PHASE_BITS-1:0]);
            start_n = 1'b1;
          end
        end
        PULSE: begin
          acc_n = acc + inc_s;
          if (cyc == t_imp_s - 1'b1) begin
            state_n = GAP;
            cyc_n = '0;
            pulse_cnt_n = pulse_cnt + 1'b1;
            addr_n = '0;
            stop_n = 1'b1;
          end else begin
            cyc_n = cyc + 1'b1;
            chip_cnt_n = chip_end ? '0 : chip_cnt + 1'b1;
            chip_idx_n = !chip_end ? chip_idx : {1'b0, chip_idx} == code_num_s - 1'b1 ? '0 : chip_idx + 1'b1;
            addr_n = rom_addr(acc_n, syms[chip_idx_n]);
          end
        end
        GAP: begin
          cyc_n = cyc + 1'b1;
          if (cyc == gap_last) begin
            cyc_n = '0;
            state_n = pulse_cnt == num_s ? IDLE : PULSE;
            if (pulse_cnt != num_s) begin
              acc_n = PHASE_CONT != 0 ? acc : '0;
              chip_cnt_n = '0;
              chip_idx_n = '0;
              addr_n = rom_addr(acc_n, syms[0]);
              start_n = 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge CLK)
    if (RESET) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge CLK)
    if (RESET) begin
      start_q <= 1'b0;
      armed <= 1'b0;
      acc <= '0;
      cyc <= '0;
      chip_cnt <= '0;
      chip_idx <= '0;
      pulse_cnt <= '0;
      ROM_ADDRESS <= '0;
      SIGN_START_CALC <= 1'b0;
      SIGN_STOP_CALC <= 1'b0;
      BUSY <= 1'b0;
      inc_s <= '0;
      t_imp_s <= '0;
      t_per_s <= '0;
      num_s <= '0;
      chip_len_s <= '0;
      code_num_s <= '0;
      code_s <= '0;
    end else begin
      start_q <= SIGN_START_GEN;
      armed <= 1'b1;
      acc <= acc_n;
      cyc <= cyc_n;
      chip_cnt <= chip_cnt_n;
      chip_idx <= chip_idx_n;
      pulse_cnt <= pulse_cnt_n;
      ROM_ADDRESS <= addr_n;
      SIGN_START_CALC <= start_n;
      SIGN_STOP_CALC <= stop_n;
      BUSY <= state_n != IDLE;
      if (load) begin
        inc_s <= PHASE_INC;
        t_imp_s <= T_IMPULSE;
        t_per_s <= T_PERIOD;
        num_s <= NUM_OF_IMP;
        chip_len_s <= CHIP_LEN;
        code_num_s <= CODE_NUM;
        code_s <= CODE;
      end
    end
endmodule

// File: tb/tb_psk_burst_phase_accum.sv
// tb_psk_burst_phase_accum: table-driven, hand-sequenced and randomized bursts checked against a burst-level model
module tb_psk_burst_phase_accum;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, ready, start_a, start_b;
  logic [31:0] phase_inc;
  logic [15:0] t_imp, t_per, chip_len;
  logic [7:0] num_imp;
  logic [4:0] code_num;
  logic [15:0] code_a;
  logic [31:0] code_b;
  logic [11:0] addr_a, addr_b;
  logic st_a, sp_a, busy_a, st_b, sp_b, busy_b;
  psk_burst_phase_accum dut_a (
    .CLK(clk), .RESET(rst), .PHASE_INC(phase_inc), .T_IMPULSE(t_imp), .T_PERIOD(t_per),
    .NUM_OF_IMP(num_imp), .CHIP_LEN(chip_len), .CODE_NUM(code_num), .CODE(code_a),
    .SIGN_START_GEN(start_a), .OUT_REG_READY(ready), .ROM_ADDRESS(addr_a),
    .SIGN_START_CALC(st_a), .SIGN_STOP_CALC(sp_a), .BUSY(busy_a)
  );
  psk_burst_phase_accum #(.PHASE_BITS(2), .PHASE_CONT(1)) dut_b (
    .CLK(clk), .RESET(rst), .PHASE_INC(phase_inc), .T_IMPULSE(t_imp), .T_PERIOD(t_per),
    .NUM_OF_IMP(num_imp), .CHIP_LEN(chip_len), .CODE_NUM(code_num), .CODE(code_b),
    .SIGN_START_GEN(start_b), .OUT_REG_READY(ready), .ROM_ADDRESS(addr_b),
    .SIGN_START_CALC(st_b), .SIGN_STOP_CALC(sp_b), .BUSY(busy_b)
  );
  typedef struct packed {
    logic [11:0] addr;
    logic st;
    logic sp;
    logic busy;
  } obs_t;
  typedef struct {
    string name;
    bit qpsk;
    logic [31:0] inc;
    int t_imp, t_per, num, chip_len, code_num;
    logic [31:0] code;
    int stall_at, stall_len, retrig_at, exp_busy;
    bit chk_addr;
    int exp_addr [8];
  } tcase_t;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] acc_b = '0;
  tcase_t tc [6];
  function automatic obs_t sample(input bit q);
    return q ? {addr_b, st_b, sp_b, busy_b} : {addr_a, st_a, sp_a, busy_a};
  endfunction
  function automatic tcase_t mk(input string name, input bit q, input logic [31:0] inc, input int ti, input int tp,
                                input int n, input int cl, input int cn, input logic [31:0] code,
                                input int sa, input int sl, input int rt, input int eb);
    tcase_t t;
    t.name = name; t.qpsk = q; t.inc = inc; t.t_imp = ti; t.t_per = tp; t.num = n;
    t.chip_len = cl; t.code_num = cn; t.code = code; t.stall_at = sa; t.stall_len = sl;
    t.retrig_at = rt; t.exp_busy = eb; t.chk_addr = 1'b0;
    for (int i = 0; i < 8; i++) t.exp_addr[i] = 0;
    return t;
  endfunction
  task automatic check_obs(input string name, input int step, input obs_t act, input obs_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s step %0d: got addr=%0d st=%0b sp=%0b busy=%0b, want addr=%0d st=%0b sp=%0b busy=%0b",
               name, step, act.addr, act.st, act.sp, act.busy, exp.addr, exp.st, exp.sp, exp.busy);
    end
  endtask
  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask
  task automatic watch_idle(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_obs({name, "_a"}, i, sample(1'b0), '0);
      check_obs({name, "_b"}, i, sample(1'b1), '0);
    end
  endtask
  task automatic run_burst(input tcase_t t);
    obs_t exp_q[$];
    obs_t cur, act;
    int idx, stall_left, busy_cnt, n_addr, gap, pb, sym, rt;
    int got_addr [8];
    logic [31:0] base, a;
    bit done;
    pb = t.qpsk ? 2 : 1;
    gap = t.t_per > t.t_imp ? t.t_per - t.t_imp : 1;
    base = t.qpsk ? acc_b : '0;
    for (int p = 0; p < t.num; p++) begin
      for (int k = 0; k < t.t_imp; k++) begin
        a = base + 32'(k) * t.inc;
        sym = int'((t.code >> (((k / t.chip_len) % t.code_num) * pb)) & ((32'd1 << pb) - 1));
        cur.addr = 12'(int'(a[31:20]) + (sym << (12 - pb)));
        cur.st = k == 0;
        cur.sp = 1'b0;
        cur.busy = 1'b1;
        exp_q.push_back(cur);
      end
      if (t.qpsk) base = base + 32'(t.t_imp) * t.inc;
      for (int j = 0; j < gap; j++) begin
        cur = {12'd0, 1'b0, j == 0, 1'b1};
        exp_q.push_back(cur);
      end
    end
    exp_q.push_back('0);
    @(negedge clk);
    phase_inc = t.inc; t_imp = 16'(t.t_imp); t_per = 16'(t.t_per); num_imp = 8'(t.num);
    chip_len = 16'(t.chip_len); code_num = 5'(t.code_num); code_a = t.code[15:0]; code_b = t.code;
    ready = 1'b1;
    if (t.qpsk) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    idx = 0; stall_left = t.stall_len; busy_cnt = 0; n_addr = 0; rt = 0; done = 1'b0;
    cur = exp_q[0];
    for (int c = 0; c < 4000; c++) begin
      act = sample(t.qpsk);
      check_obs(t.name, idx, act, cur);
      if (act.busy) busy_cnt++;
      if (n_addr < 8) begin
        got_addr[n_addr] = int'(act.addr);
        n_addr++;
      end
      if (idx == exp_q.size() - 1) begin
        done = 1'b1;
        break;
      end
      ready = !(idx == t.stall_at && stall_left > 0);
      if (!ready) stall_left--;
      if (rt == 1) begin
        start_a = 1'b0; start_b = 1'b0; rt = 2;
      end else if (rt == 0 && idx == t.retrig_at) begin
        if (t.qpsk) start_b = 1'b1; else start_a = 1'b1;
        phase_inc = $urandom; t_imp = 16'd3; num_imp = 8'd9; code_a = 16'hffff; code_b = '1;
        rt = 1;
      end
      @(negedge clk);
      if (ready) idx++;
      cur = exp_q[idx];
      if (!ready) begin
        cur.st = 1'b0;
        cur.sp = 1'b0;
      end
    end
    ready = 1'b1; start_a = 1'b0; start_b = 1'b0;
    if (!done) begin
      miscompares++;
      $display("FAIL %s: burst did not return to idle within cycle budget", t.name);
    end
    check_int({t.name, "_busy_cycles"}, busy_cnt, t.exp_busy);
    if (t.chk_addr)
      for (int i = 0; i < 8; i++) check_int($sformatf("%s_addr%0d", t.name, i), got_addr[i], t.exp_addr[i]);
    if (t.qpsk) acc_b = base;
  endtask
  task automatic degen(input string name, input int n, input int cl);
    @(negedge clk);
    phase_inc = 32'h0010_0000; t_imp = 16'd8; t_per = 16'd12; num_imp = 8'(n); chip_len = 16'(cl);
    code_num = 5'd1; code_a = '0; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check_obs(name, 0, sample(1'b0), '0);
    watch_idle(name, 5);
  endtask
  initial begin
    tcase_t r;
    int gap, bl;
    tc[0] = mk("basic", 0, 32'h0010_0000, 8, 12, 2, 8, 1, 32'h0, -1, 0, -1, 24);
    tc[0].chk_addr = 1; tc[0].exp_addr = '{0, 1, 2, 3, 4, 5, 6, 7};
    tc[1] = mk("bpsk", 0, 32'h0, 8, 10, 1, 2, 3, 32'b010, -1, 0, -1, 10);
    tc[1].chk_addr = 1; tc[1].exp_addr = '{0, 0, 2048, 2048, 0, 0, 0, 0};
    tc[2] = mk("qpsk_cont", 1, 32'h0010_0000, 4, 6, 2, 4, 1, 32'b11, -1, 0, -1, 12);
    tc[2].chk_addr = 1; tc[2].exp_addr = '{3072, 3073, 3074, 3075, 0, 0, 3076, 3077};
    tc[3] = mk("backpressure", 0, 32'h0010_0000, 8, 12, 2, 8, 1, 32'h0, 3, 3, -1, 27);
    tc[3].chk_addr = 1; tc[3].exp_addr = '{0, 1, 2, 3, 3, 3, 3, 4};
    tc[4] = mk("short_gap", 0, 32'h0010_0000, 10, 2, 2, 3, 2, 32'b10, -1, 0, -1, 22);
    tc[4].chk_addr = 1; tc[4].exp_addr = '{0, 1, 2, 2051, 2052, 2053, 6, 7};
    tc[5] = mk("retrigger", 0, 32'h0010_0000, 8, 12, 2, 8, 1, 32'h0, -1, 0, 4, 24);
    rst = 1'b1; ready = 1'b1; start_a = 1'b0; start_b = 1'b0;
    phase_inc = '0; t_imp = '0; t_per = '0; num_imp = '0; chip_len = '0; code_num = '0; code_a = '0; code_b = '0;
    repeat (3) @(negedge clk);
    check_obs("in_reset_a", 0, sample(1'b0), '0);
    check_obs("in_reset_b", 0, sample(1'b1), '0);
    rst = 1'b0;
    watch_idle("after_reset", 2);
    for (int i = 0; i < 6; i++) run_burst(tc[i]);
    degen("num0", 0, 8);
    degen("chiplen0", 2, 0);
    for (int i = 0; i < 20; i++) begin
      r = mk("random", 1'($urandom), $urandom, int'($urandom_range(1, 12)), int'($urandom_range(0, 16)),
             int'($urandom_range(1, 3)), int'($urandom_range(1, 4)), int'($urandom_range(1, 16)), $urandom,
             -1, int'($urandom_range(0, 3)), -1, 0);
      r.name = $sformatf("random%0d", i);
      gap = r.t_per > r.t_imp ? r.t_per - r.t_imp : 1;
      bl = r.num * (r.t_imp + gap);
      r.stall_at = int'($urandom_range(0, bl - 1));
      r.exp_busy = bl + r.stall_len;
      run_burst(r);
    end
    @(negedge clk);
    phase_inc = 32'h0010_0000; t_imp = 16'd8; t_per = 16'd12; num_imp = 8'd2; chip_len = 16'd8;
    code_num = 5'd1; code_a = '0; code_b = 32'b11; start_a = 1'b1; start_b = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1; ready = 1'b0;
    @(negedge clk);
    check_obs("reset_mid_pulse_a", 0, sample(1'b0), '0);
    check_obs("reset_mid_pulse_b", 0, sample(1'b1), '0);
    rst = 1'b0; ready = 1'b1; acc_b = '0;
    watch_idle("post_abort", 4);
    rst = 1'b1; start_a = 1'b1; start_b = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    watch_idle("start_held_over_reset", 6);
    start_a = 1'b0; start_b = 1'b0;
    run_burst(tc[0]);
    run_burst(tc[2]);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
